rr_arbiter_n: RTL and testbench
===============================

# rr_arbiter_n

Parametrised N-channel arbiter: the generalised successor to the team's 4-input fixed-priority grant register. It accepts N request lines, issues a registered one-hot grant plus encoded index, and supports fixed-priority or round-robin selection. The grant locks while the holder keeps requesting, with an optional hold-limit for fairness. It sits between the request sources and the shared-resource mux in the round-robin arbiter datapath.

## Interface
- N, 4: number of requesters; legal range 2..32.
- MODE, 1: 0 = fixed priority, req[0] highest; 1 = round-robin.
- MAX_HOLD, 8: maximum consecutive grant cycles before forced rotation; used only when the hold limit is compiled in; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbitration enable; low clears the grant on the next edge.
- req  input  N  request vector, one bit per requester, level-sensitive.
- gnt  output  N  registered one-hot grant; all-zero when nothing is granted.
- gnt_valid  output  1  high when gnt is non-zero.
- gnt_idx  output  clog2(N)  binary index of the granted bit; 0 when gnt_valid=0.

## Operation
- Two states: IDLE (gnt=0) and GRANT (exactly one gnt bit set).
- **Selection function**
  - MODE 0: lowest set index of the candidate vector.
  - MODE 1: first set index at or above ptr, wrapping from N-1 to 0.
  - ptr register is clog2(N) wide and resets to 0.
  - On every new grant to index k, ptr <= (k+1) mod N; N not a power of two wraps explicitly.
- **IDLE**
  - en=1 and |req=1: select from req, load gnt/gnt_idx, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**, en=1, holder index h:
  - req[h]=1 and the hold limit is not reached: hold gnt unchanged.
  - req[h]=0 and other requests pending: select from req and switch directly to the new holder. There is no idle bubble.
  - req[h]=0 and no other requests: go to IDLE, gnt=0.
- **en=0** in any state: next edge gives gnt=0 and IDLE. ptr and hold counter are retained and cleared respectively.
- **Forced rotation** (hold limit compiled in): when the holder has held for MAX_HOLD cycles, req[h] is still 1, and req with bit h masked is non-zero:
  - Select from the masked vector and switch holders.
  - If the masked vector is zero, keep the grant; the counter saturates at MAX_HOLD.
- Hold counter clears to 1 on every new grant, increments each held cycle, and clears to 0 in IDLE.
- Requests arriving while a grant is held only take effect at the next arbitration point.
- gnt, gnt_valid and gnt_idx are updated together from registers and are always mutually consistent.

## Timing
- Reset values: gnt=0, gnt_valid=0, gnt_idx=0, ptr=0, hold counter=0, state IDLE.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge.
- Latency: req sampled at edge t gives gnt visible after edge t (1 cycle). No combinational path from req or en to the outputs.
- Handover latency: holder drops req at edge t; new grant appears after edge t, giving zero idle cycles.
- Simultaneous holder drop and forced rotation resolve identically: select from req with h excluded.
- en rising while req is stable gives a grant one cycle later.

## Configuration
- ARB_HOLD_LIMIT_EN defined:
  - Hold counter and forced rotation are implemented; MAX_HOLD is honoured.
- ARB_HOLD_LIMIT_EN undefined:
  - No counter is built; MAX_HOLD is ignored.
  - A holder keeps the grant for as long as req[h]=1 and en=1.

## Test plan
- Reset mid-grant: N=4, MODE=1, req=4'b0110 granted (gnt=4'b0010), assert rst between edges -> gnt=0, gnt_idx=0, gnt_valid=0 immediately. After release, req=4'b0110 -> gnt=4'b0010 (ptr back at 0).
- Fixed priority: MODE=0, req=4'b1100 -> gnt=4'b0100. Drop req[2] -> gnt=4'b1000 on the very next cycle, no zero cycle between.
- Round-robin fairness: MODE=1, req pulses each holder for 1 cycle with all 4 requesting -> grant order idx 0,1,2,3,0. Confirm ptr wrap; repeat with N=3 -> 0,1,2,0.
- Enable gating: while gnt=4'b0001, drop en -> gnt=0 next cycle. Raise en with req=4'b0011 in MODE 1 -> gnt=4'b0010 (ptr retained at 1).
- Hold limit (ARB_HOLD_LIMIT_EN, MAX_HOLD=3): req=4'b0011 held constant -> gnt 0001 for 3 cycles, then 0010 for 3, then 0001. With req=4'b0001 only -> grant held indefinitely.
- Without macro: same req=4'b0011 constant -> gnt=4'b0001 for 50 cycles, never rotates.

Source files
------------

// File: rtl/rr_arbiter_n.sv
// N-channel arbiter with registered one-hot grant, fixed-priority or round-robin selection.
// Optional hold limit with forced rotation is built only when ARB_HOLD_LIMIT_EN is defined.
//
// state | meaning
// IDLE  | no grant outstanding, gnt = 0
// GRANT | exactly one gnt bit set, holder index in gnt_idx
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N-1:0]           req,
    output logic [N-1:0]           gnt,
    output logic                   gnt_valid,
    output logic [$clog2(N)-1:0]   gnt_idx
);

    localparam int IW = $clog2(N);

    if (N < 2 || N > 32) begin : g_bad_n
        $error("rr_arbiter_n: N must be in 2..32");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_arbiter_n: MAX_HOLD must be in 1..255");
    end

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   gnt_q, gnt_nxt;
    logic [IW-1:0]  idx_q, idx_nxt;
    logic [IW-1:0]  ptr, ptr_nxt;
    logic [N-1:0]   masked, cand;
    logic [IW-1:0]  sel_idx, ptr_inc;
    logic           sel_found;
    logic           holder_req;
    logic           limit_hit;
    logic           take_new;

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    logic [7:0] hold_q, hold_nxt;
    assign limit_hit = (hold_q >= HOLD_MAX);
`else
    assign limit_hit = 1'b0;
`endif

    assign masked     = req & ~gnt_q;
    assign holder_req = |(req & gnt_q);
    assign cand       = (state == IDLE) ? req : masked;

    // Scan starts at ptr in round-robin mode and at 0 in fixed-priority mode.
    always_comb begin
        int start;
        int j;
        sel_idx   = '0;
        sel_found = 1'b0;
        start     = (MODE == 1) ? int'(ptr) : 0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            j = start + i;
            if (j >= N) j = j - N;
            if (!sel_found && cand[IW'(j)]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(j);
            end
        end
    end

    assign ptr_inc = (sel_idx == IW'(N - 1)) ? '0 : sel_idx + IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt_q  <= '0;
            idx_q  <= '0;
            ptr    <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_q <= '0;
`endif
        end else begin
            state  <= state_nxt;
            gnt_q  <= gnt_nxt;
            idx_q  <= idx_nxt;
            ptr    <= ptr_nxt;
`ifdef ARB_HOLD_LIMIT_EN
            hold_q <= hold_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        idx_nxt   = idx_q;
        ptr_nxt   = ptr;
        take_new  = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) take_new = 1'b1;
                end
                GRANT: begin
                    // Holder drop and forced rotation both pick from req with the holder masked.
                    if (!holder_req || (limit_hit && |masked)) begin
                        if (|masked) begin
                            take_new = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            gnt_nxt   = '0;
                            idx_nxt   = '0;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
        if (take_new) begin
            state_nxt = GRANT;
            gnt_nxt   = N'(1) << sel_idx;
            idx_nxt   = sel_idx;
            ptr_nxt   = ptr_inc;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    always_comb begin
        hold_nxt = hold_q;
        if (take_new)
            hold_nxt = 8'd1;
        else if (state_nxt == IDLE)
            hold_nxt = '0;
        else if (hold_q < HOLD_MAX)
            hold_nxt = hold_q + 8'd1;
    end
`endif

    always_comb begin
        gnt       = gnt_q;
        gnt_idx   = idx_q;
        gnt_valid = (state == GRANT);
    end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: round-robin, fixed priority, N=3 wrap, reset, enable and hold limit.
module tb_rr_arbiter_n;

    logic clk, rst, en;
    logic [3:0] req_rr4, req_fp4, req_hl;
    logic [2:0] req_rr3;
    logic [3:0] gnt_rr4, gnt_fp4, gnt_hl;
    logic [2:0] gnt_rr3;
    logic [1:0] idx_rr4, idx_fp4, idx_hl, idx_rr3;
    logic       v_rr4, v_fp4, v_hl, v_rr3;

    int pass_cnt = 0;
    int total    = 0;

    rr_arbiter_n #(.N(4), .MODE(1), .MAX_HOLD(8)) u_rr4 (
        .clk(clk), .rst(rst), .en(en), .req(req_rr4),
        .gnt(gnt_rr4), .gnt_valid(v_rr4), .gnt_idx(idx_rr4));
    rr_arbiter_n #(.N(4), .MODE(0), .MAX_HOLD(8)) u_fp4 (
        .clk(clk), .rst(rst), .en(en), .req(req_fp4),
        .gnt(gnt_fp4), .gnt_valid(v_fp4), .gnt_idx(idx_fp4));
    rr_arbiter_n #(.N(3), .MODE(1), .MAX_HOLD(8)) u_rr3 (
        .clk(clk), .rst(rst), .en(en), .req(req_rr3),
        .gnt(gnt_rr3), .gnt_valid(v_rr3), .gnt_idx(idx_rr3));
    rr_arbiter_n #(.N(4), .MODE(1), .MAX_HOLD(3)) u_hl (
        .clk(clk), .rst(rst), .en(en), .req(req_hl),
        .gnt(gnt_hl), .gnt_valid(v_hl), .gnt_idx(idx_hl));

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt;
        int         idx;
    } vec_t;

    typedef struct {
        logic [2:0] req;
        logic [2:0] gnt;
        int         idx;
    } vec3_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en  = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] eg,
                       input int ix, input int eix, input logic v, input logic ev);
        total++;
        if (g === eg && ix == eix && v === ev)
            pass_cnt++;
        else
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b, want gnt=%b idx=%0d valid=%b",
                     nm, g, ix, v, eg, eix, ev);
    endtask

    vec_t  vecs[14];
    vec3_t v3[4];

    initial begin
        logic [3:0] eg;
        int         ei;
        clk = 1'b0; rst = 1'b1; en = 1'b0;
        req_rr4 = '0; req_fp4 = '0; req_hl = '0; req_rr3 = '0;

        vecs[0]  = '{1'b1, 4'b1111, 4'b0001, 0};
        vecs[1]  = '{1'b1, 4'b1110, 4'b0010, 1};
        vecs[2]  = '{1'b1, 4'b1101, 4'b0100, 2};
        vecs[3]  = '{1'b1, 4'b1011, 4'b1000, 3};
        vecs[4]  = '{1'b1, 4'b0111, 4'b0001, 0};
        vecs[5]  = '{1'b1, 4'b0001, 4'b0001, 0};
        vecs[6]  = '{1'b1, 4'b0011, 4'b0001, 0};
        vecs[7]  = '{1'b0, 4'b0011, 4'b0000, 0};
        vecs[8]  = '{1'b1, 4'b0011, 4'b0010, 1};
        vecs[9]  = '{1'b1, 4'b0000, 4'b0000, 0};
        vecs[10] = '{1'b1, 4'b1001, 4'b1000, 3};
        vecs[11] = '{1'b1, 4'b0000, 4'b0000, 0};
        vecs[12] = '{1'b0, 4'b0001, 4'b0000, 0};
        vecs[13] = '{1'b1, 4'b0001, 4'b0001, 0};

        v3[0] = '{3'b111, 3'b001, 0};
        v3[1] = '{3'b110, 3'b010, 1};
        v3[2] = '{3'b101, 3'b100, 2};
        v3[3] = '{3'b011, 3'b001, 0};

        #12;
        chk("reset_rr4", 32'(gnt_rr4), 32'd0, int'(idx_rr4), 0, v_rr4, 1'b0);
        chk("reset_hl",  32'(gnt_hl),  32'd0, int'(idx_hl),  0, v_hl,  1'b0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            en      = vecs[i].en;
            req_rr4 = vecs[i].req;
            tick();
            chk($sformatf("rr4_vec%0d", i), 32'(gnt_rr4), 32'(vecs[i].gnt),
                int'(idx_rr4), vecs[i].idx, v_rr4, |vecs[i].gnt);
        end

        // Asynchronous reset mid-grant, then ptr must be back at 0.
        do_reset();
        en = 1'b1; req_rr4 = 4'b0110;
        tick();
        chk("rst_pre", 32'(gnt_rr4), 32'b0010, int'(idx_rr4), 1, v_rr4, 1'b1);
        #3; rst = 1'b1; #1;
        chk("rst_async", 32'(gnt_rr4), 32'd0, int'(idx_rr4), 0, v_rr4, 1'b0);
        #1; rst = 1'b0; en = 1'b1;
        tick();
        chk("rst_post", 32'(gnt_rr4), 32'b0010, int'(idx_rr4), 1, v_rr4, 1'b1);

        // Fixed priority with direct handover.
        do_reset();
        en = 1'b1; req_fp4 = 4'b1100;
        tick();
        chk("fp_first", 32'(gnt_fp4), 32'b0100, int'(idx_fp4), 2, v_fp4, 1'b1);
        req_fp4 = 4'b1000;
        tick();
        chk("fp_handover", 32'(gnt_fp4), 32'b1000, int'(idx_fp4), 3, v_fp4, 1'b1);
        req_fp4 = 4'b0000;
        tick();
        chk("fp_idle", 32'(gnt_fp4), 32'd0, int'(idx_fp4), 0, v_fp4, 1'b0);
        req_fp4 = 4'b0100;
        tick();
        req_fp4 = 4'b0000;
        tick();
        req_fp4 = 4'b1010;
        tick();
        chk("fp_lowest", 32'(gnt_fp4), 32'b0010, int'(idx_fp4), 1, v_fp4, 1'b1);

        // N=3 round-robin wrap.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_rr3 = v3[i].req;
            tick();
            chk($sformatf("rr3_vec%0d", i), 32'(gnt_rr3), 32'(v3[i].gnt),
                int'(idx_rr3), v3[i].idx, v_rr3, 1'b1);
        end
        req_rr3 = '0;

        // Hold limit (MAX_HOLD=3) or unlimited hold, depending on build.
        do_reset();
        en = 1'b1; req_hl = 4'b0011;
        for (int c = 1; c <= 50; c++) begin
            tick();
`ifdef ARB_HOLD_LIMIT_EN
            if (((c - 1) / 3) % 2 == 0) begin eg = 4'b0001; ei = 0; end
            else                        begin eg = 4'b0010; ei = 1; end
`else
            eg = 4'b0001; ei = 0;
`endif
            chk($sformatf("hold_c%0d", c), 32'(gnt_hl), 32'(eg), int'(idx_hl), ei, v_hl, 1'b1);
        end
        req_hl = 4'b0001;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk($sformatf("hold_solo%0d", c), 32'(gnt_hl), 32'b0001, int'(idx_hl), 0, v_hl, 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
